// File: rtl/soqpsk_pkg.sv
// Shared constants, alpha encoding and FSM state type for the SOQPSK shaping-ROM sequencer.
package soqpsk_pkg;

    localparam logic [1:0] ALPHA_ZERO = 2'b00;
    localparam logic [1:0] ALPHA_POS  = 2'b01;
    localparam logic [1:0] ALPHA_NEG  = 2'b11;

    localparam int unsigned SPB    = 32;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned ADDR_W = 9;

    localparam int unsigned ADDR_IDX_LSB  = 0;
    localparam int unsigned ADDR_CUR_LSB  = 5;
    localparam int unsigned ADDR_PREV_LSB = 7;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SPB - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    function automatic logic [ADDR_W-1:0] make_addr(input logic [1:0]       prev,
                                                    input logic [1:0]       cur,
                                                    input logic [IDX_W-1:0] idx);
        logic [ADDR_W-1:0] a;
        a = '0;
        a[ADDR_PREV_LSB +: 2]    = prev;
        a[ADDR_CUR_LSB +: 2]     = cur;
        a[ADDR_IDX_LSB +: IDX_W] = idx;
        return a;
    endfunction

endpackage

// File: rtl/soqpsk_precoder.sv
// Combinational SOQPSK precoder: alpha_k = (-1)^(k+1) * a_{k-1} * (a_k - a_{k-2}) / 2.
module soqpsk_precoder
    import soqpsk_pkg::*;
(
    input  logic       i_bit,
    input  logic       i_hist1,
    input  logic       i_hist2,
    input  logic       i_parity,
    output logic [1:0] o_alpha
);

    logic w_neg;

    // Each of {k even, a_{k-1} = -1, a_k = -1} contributes one sign flip.
    assign w_neg = ~(i_parity ^ i_hist1 ^ i_bit);

    always_comb begin
        o_alpha = ALPHA_ZERO;
        if (i_bit != i_hist2) begin
            o_alpha = w_neg ? ALPHA_NEG : ALPHA_POS;
        end
    end

endmodule

// File: rtl/soqpsk_lut_sequencer.sv
// Walks the registered-output shaping ROM through 32 samples per precoded symbol and
// accumulates the returned frequency pulse into a running phase.
module soqpsk_lut_sequencer
    import soqpsk_pkg::*;
#(
    parameter int unsigned LUT_LATENCY = 1,
    parameter int unsigned PHASE_W     = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               bit_in,
    input  logic               bit_valid,
    output logic               bit_ready,
    output logic [8:0]         lut_address,
    input  logic [13:0]        lut_q,
    output logic [13:0]        sample_out,
    output logic               sample_valid,
    output logic [PHASE_W-1:0] phase_out,
    output logic               underflow,
    output logic               busy
);

    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [1:0]             r_prev;
    logic [1:0]             r_cur;
    logic                   r_hist1;
    logic                   r_hist2;
    logic                   r_parity;
    logic [ADDR_W-1:0]      r_addr;
    logic                   r_addr_vld;
    logic                   r_underflow;
    logic [LUT_LATENCY-1:0] r_pipe;
    logic [13:0]            r_sample;
    logic                   r_sample_vld;
    logic [PHASE_W-1:0]     r_phase;

    logic [1:0]             w_alpha;
    logic                   w_accept;
    logic [PHASE_W-1:0]     w_q_ext;

    soqpsk_precoder u_precoder (
        .i_bit    (bit_in),
        .i_hist1  (r_hist1),
        .i_hist2  (r_hist2),
        .i_parity (r_parity),
        .o_alpha  (w_alpha)
    );

    // Ready depends only on registered state, never on bit_valid.
    assign bit_ready = (r_state == IDLE) || (r_idx == IDX_LAST);
    assign w_accept  = bit_valid && bit_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_prev      <= ALPHA_ZERO;
            r_cur       <= ALPHA_ZERO;
            r_hist1     <= 1'b1;
            r_hist2     <= 1'b1;
            r_parity    <= 1'b0;
            r_addr      <= '0;
            r_addr_vld  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_addr_vld  <= 1'b0;
            r_underflow <= 1'b0;
            if (w_accept) begin
                r_state    <= RUN;
                r_prev     <= r_cur;
                r_cur      <= w_alpha;
                r_idx      <= '0;
                r_hist1    <= bit_in;
                r_hist2    <= r_hist1;
                r_parity   <= ~r_parity;
                r_addr     <= make_addr(r_cur, w_alpha, '0);
                r_addr_vld <= 1'b1;
            end else if (r_state == RUN) begin
                if (r_idx != IDX_LAST) begin
                    r_idx      <= r_idx + IDX_W'(1);
                    r_addr     <= make_addr(r_prev, r_cur, r_idx + IDX_W'(1));
                    r_addr_vld <= 1'b1;
                end else begin
                    r_state     <= IDLE;
                    r_underflow <= 1'b1;
                end
            end
        end
    end

    assign w_q_ext = PHASE_W'($signed(lut_q));

    // r_pipe[LUT_LATENCY-1] marks the cycle in which lut_q holds a tracked address's data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe       <= '0;
            r_sample     <= '0;
            r_sample_vld <= 1'b0;
            r_phase      <= '0;
        end else begin
            r_pipe[0] <= r_addr_vld;
            for (int i = 1; i < int'(LUT_LATENCY); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            r_sample_vld <= r_pipe[LUT_LATENCY-1];
            if (r_pipe[LUT_LATENCY-1]) begin
                r_sample <= lut_q;
                r_phase  <= r_phase + w_q_ext;
            end
        end
    end

    assign lut_address  = r_addr;
    assign sample_out   = r_sample;
    assign sample_valid = r_sample_vld;
    assign phase_out    = r_phase;
    assign underflow    = r_underflow;
    assign busy         = (r_state == RUN);

endmodule
